ysyx_23060208_ifu_fetch: RTL and testbench

Instruction-fetch read initiator: holds the fetch PC and issues one AXI-lite-style read (AR channel), accepts the read response (R channel), and presents the instruction to the decode stage over a valid/allowin handshake. It is the requesting end of the isram read interface and sits between the isram responder and IDU. It allows one outstanding read at a time and supports redirects (branch/jump) at any point in the fetch.

---
 rtl/ysyx_23060208_ifu_fetch_if.sv | 33 +++
 rtl/ysyx_23060208_ifu_fetch.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060208_ifu_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_ifu_fetch_if.sv
// isram read channel between the fetch unit (master) and the instruction
// memory responder (slave): AR request plus R response.
interface ysyx_23060208_ifu_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ifu_araddr;
    logic                  ifu_arvalid;
    logic                  ifu_arready;
    logic [1:0]            ifu_rresp;
    logic                  ifu_rvalid;
    logic [DATA_WIDTH-1:0] ifu_rdata;
    logic                  ifu_rready;

    modport master (
        output ifu_araddr,
        output ifu_arvalid,
        output ifu_rready,
        input  ifu_arready,
        input  ifu_rresp,
        input  ifu_rvalid,
        input  ifu_rdata
    );

    modport slave (
        input  ifu_araddr,
        input  ifu_arvalid,
        input  ifu_rready,
        output ifu_arready,
        output ifu_rresp,
        output ifu_rvalid,
        output ifu_rdata
    );
endinterface

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch initiator: one outstanding isram read at a time, hands the
// word to IDU over valid/allowin, and absorbs redirects at any fetch phase.
module ysyx_23060208_ifu_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h8000_0000)
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060208_ifu_fetch_if.master    isram,
    input  logic                         redirect_valid,
    input  logic [DATA_WIDTH-1:0]        redirect_pc,
    output logic                         to_idu_valid,
    output logic [DATA_WIDTH-1:0]        to_idu_inst,
    output logic [DATA_WIDTH-1:0]        to_idu_pc,
    output logic                         fetch_err,
    input  logic                         idu_allowin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  drop_q, drop_d;
    logic                  latch_inst;

    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] inst_pc_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] target;

    // Redirect targets are always word aligned.
    assign target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        drop_d     = drop_q;
        latch_inst = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_AR;
                if (redirect_valid) begin
                    pc_d = target;
                end
            end

            S_AR: begin
                // The request already on the bus is never retracted; remember
                // the new target and throw its response away later.
                if (redirect_valid) begin
                    pend_pc_d = target;
                    drop_d    = 1'b1;
                end
                if (isram.ifu_arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (isram.ifu_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        pc_d    = redirect_valid ? target : pend_pc_q;
                        state_d = S_AR;
                    end else begin
                        latch_inst = 1'b1;
                        state_d    = S_OUT;
                    end
                end else if (redirect_valid) begin
                    pend_pc_d = target;
                    drop_d    = 1'b1;
                end
            end

            S_OUT: begin
                // A redirect cancels the held instruction even if IDU takes it.
                if (redirect_valid) begin
                    pc_d    = target;
                    state_d = S_AR;
                end else if (idu_allowin) begin
                    pc_d    = pc_q + DATA_WIDTH'(4);
                    state_d = S_AR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
        end else if (latch_inst) begin
            inst_q    <= isram.ifu_rdata;
            inst_pc_q <= pc_q;
            err_q     <= (isram.ifu_rresp != 2'b00);
        end
    end

    // Every output comes from registered state only.
    assign isram.ifu_araddr  = pc_q;
    assign isram.ifu_arvalid = (state_q == S_AR);
    assign isram.ifu_rready  = (state_q == S_R);
    assign to_idu_valid      = (state_q == S_OUT);
    assign to_idu_inst       = inst_q;
    assign to_idu_pc         = inst_pc_q;
    assign fetch_err         = err_q;

    a_one_phase: assert property (@(posedge clk) disable iff (rst)
        $onehot0({isram.ifu_arvalid, isram.ifu_rready, to_idu_valid}));

    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        isram.ifu_arvalid && !isram.ifu_arready |=>
            isram.ifu_arvalid && $stable(isram.ifu_araddr));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        to_idu_valid && !idu_allowin && !redirect_valid |=>
            to_idu_valid && $stable(to_idu_inst) && $stable(to_idu_pc) && $stable(fetch_err));

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Bench for ysyx_23060208_ifu_fetch: directed scenarios then random traffic,
// all checked every cycle against a transaction-level fetch model.
module tb_ysyx_23060208_ifu_fetch;

    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060208_ifu_fetch_if #(.DATA_WIDTH(DW)) bus ();

    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          to_idu_valid;
    logic [DW-1:0] to_idu_inst;
    logic [DW-1:0] to_idu_pc;
    logic          fetch_err;
    logic          idu_allowin;

    ysyx_23060208_ifu_fetch #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .isram          (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .to_idu_valid   (to_idu_valid),
        .to_idu_inst    (to_idu_inst),
        .to_idu_pc      (to_idu_pc),
        .fetch_err      (fetch_err),
        .idu_allowin    (idu_allowin)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fetch model: where the next fetch goes, which request is live, whether
    // its response is doomed, and what IDU currently sees.
    typedef enum int {P_START, P_REQ, P_WAIT, P_SHOW} phase_t;
    phase_t      m_phase;
    logic [31:0] m_next;
    logic [31:0] m_req;
    logic        m_doomed;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_err;

    task automatic model_reset();
        m_phase  = P_START;
        m_next   = RESET_PC;
        m_req    = RESET_PC;
        m_doomed = 1'b0;
        m_inst   = '0;
        m_pc     = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        case (m_phase)
            P_START: begin
                if (redirect_valid) m_next = tgt;
                m_req   = m_next;
                m_phase = P_REQ;
            end
            P_REQ: begin
                if (redirect_valid) begin
                    m_next   = tgt;
                    m_doomed = 1'b1;
                end
                if (bus.ifu_arready) m_phase = P_WAIT;
            end
            P_WAIT: begin
                if (bus.ifu_rvalid) begin
                    if (m_doomed || redirect_valid) begin
                        if (redirect_valid) m_next = tgt;
                        m_doomed = 1'b0;
                        m_req    = m_next;
                        m_phase  = P_REQ;
                    end else begin
                        m_inst  = bus.ifu_rdata;
                        m_pc    = m_req;
                        m_err   = (bus.ifu_rresp != 2'b00);
                        m_phase = P_SHOW;
                    end
                end else if (redirect_valid) begin
                    m_next   = tgt;
                    m_doomed = 1'b1;
                end
            end
            default: begin
                if (redirect_valid) begin
                    m_next  = tgt;
                    m_req   = tgt;
                    m_phase = P_REQ;
                end else if (idu_allowin) begin
                    m_req   = m_req + 32'd4;
                    m_next  = m_req;
                    m_phase = P_REQ;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("arvalid", bus.ifu_arvalid, m_phase == P_REQ);
        check("rready", bus.ifu_rready, m_phase == P_WAIT);
        check("to_idu_valid", to_idu_valid, m_phase == P_SHOW);
        check("araddr", bus.ifu_araddr, (m_phase == P_START) ? m_next : m_req);
        check("to_idu_inst", to_idu_inst, m_inst);
        check("to_idu_pc", to_idu_pc, m_pc);
        check("fetch_err", fetch_err, m_err);
    endtask

    // Responder and stimulus knobs.
    int          ar_pct, dly_min, dly_max, redir_pct, allow_pct;
    bit          spur_en, ovr_en;
    logic [31:0] ovr_data;
    logic [1:0]  ovr_resp;

    bit          resp_pending;
    int          resp_wait;
    logic [31:0] resp_addr;

    task automatic drive();
        bus.ifu_arready = ($urandom_range(0, 99) < ar_pct);
        if (resp_pending && resp_wait == 0) begin
            bus.ifu_rvalid = 1'b1;
            bus.ifu_rdata  = ovr_en ? ovr_data : (resp_addr ^ 32'h5A5A_1234);
            bus.ifu_rresp  = ovr_en ? ovr_resp :
                             (($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end else begin
            bus.ifu_rvalid = spur_en && ($urandom_range(0, 7) == 0);
            bus.ifu_rdata  = $urandom;
            bus.ifu_rresp  = 2'($urandom_range(0, 3));
        end
        redirect_valid = ($urandom_range(0, 99) < redir_pct);
        redirect_pc    = $urandom;
        idu_allowin    = ($urandom_range(0, 99) < allow_pct);
    endtask

    task automatic tick();
        bit          hs_ar, hs_r;
        logic [31:0] hs_addr;
        hs_ar   = bus.ifu_arvalid && bus.ifu_arready;
        hs_r    = bus.ifu_rready && bus.ifu_rvalid;
        hs_addr = bus.ifu_araddr;
        @(posedge clk);
        if (!rst) model_edge();
        if (rst) begin
            resp_pending = 1'b0;
        end else begin
            if (resp_pending) begin
                if (hs_r) resp_pending = 1'b0;
                else if (resp_wait > 0) resp_wait--;
            end
            if (hs_ar) begin
                resp_pending = 1'b1;
                resp_addr    = hs_addr;
                resp_wait    = $urandom_range(dly_min, dly_max);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    typedef enum int {W_AR, W_R, W_VALID} wait_t;

    function automatic logic cond_of(wait_t w);
        case (w)
            W_AR:    return bus.ifu_arvalid;
            W_R:     return bus.ifu_rready;
            default: return to_idu_valid;
        endcase
    endfunction

    task automatic run_until(input wait_t w, input int budget, input string tag);
        int n = 0;
        while (!cond_of(w) && n < budget) begin
            drive();
            tick();
            n++;
        end
        check({tag, "_reached"}, cond_of(w), 1'b1);
    endtask

    // Reset asserted between clock edges; outputs must fall without a clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_arvalid"}, bus.ifu_arvalid, 1'b0);
        check({tag, "_rready"}, bus.ifu_rready, 1'b0);
        check({tag, "_valid"}, to_idu_valid, 1'b0);
        check({tag, "_araddr"}, bus.ifu_araddr, RESET_PC);
        model_reset();
        resp_pending = 1'b0;
        drive();
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_dropped(input string tag, input logic [31:0] next_addr);
        bit saw_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.ifu_arvalid; i++) begin
            drive();
            tick();
            if (to_idu_valid) saw_valid = 1'b1;
        end
        check({tag, "_no_valid"}, saw_valid, 1'b0);
        check({tag, "_arvalid"}, bus.ifu_arvalid, 1'b1);
        check({tag, "_araddr"}, bus.ifu_araddr, next_addr);
    endtask

    logic [31:0] cap_inst, cap_pc;

    initial begin
        rst = 1'b1;
        bus.ifu_arready = 1'b0;
        bus.ifu_rvalid  = 1'b0;
        bus.ifu_rdata   = '0;
        bus.ifu_rresp   = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        idu_allowin     = 1'b0;
        ar_pct = 100; dly_min = 0; dly_max = 0; redir_pct = 0; allow_pct = 100;
        spur_en = 1'b0; ovr_en = 1'b1; ovr_data = 32'h0000_0413; ovr_resp = 2'b00;
        resp_pending = 1'b0; resp_wait = 0; resp_addr = '0;
        model_reset();

        // Reset state and first fetch.
        @(negedge clk);
        check_outputs();
        check("rst_araddr", bus.ifu_araddr, 32'h8000_0000);
        check("rst_valid", to_idu_valid, 1'b0);
        rst = 1'b0;
        run_until(W_AR, 3, "t1_ar0");
        check("t1_araddr0", bus.ifu_araddr, 32'h8000_0000);
        run_until(W_VALID, 6, "t1_out");
        check("t1_inst", to_idu_inst, 32'h0000_0413);
        check("t1_pc", to_idu_pc, 32'h8000_0000);
        ovr_data = 32'h0010_0093;
        drive();
        tick();
        run_until(W_AR, 3, "t1_ar1");
        check("t1_araddr1", bus.ifu_araddr, 32'h8000_0004);

        // IDU stalls for five cycles.
        run_until(W_VALID, 6, "t2_out");
        cap_inst = to_idu_inst;
        cap_pc   = to_idu_pc;
        check("t2_pc", cap_pc, 32'h8000_0004);
        check("t2_inst", cap_inst, 32'h0010_0093);
        allow_pct = 0;
        repeat (5) begin
            drive();
            tick();
            check("t2_hold_valid", to_idu_valid, 1'b1);
            check("t2_hold_inst", to_idu_inst, 32'h0010_0093);
            check("t2_hold_pc", to_idu_pc, 32'h8000_0004);
            check("t2_hold_arvalid", bus.ifu_arvalid, 1'b0);
            check("t2_hold_rready", bus.ifu_rready, 1'b0);
        end
        allow_pct = 100;
        drive();
        tick();
        check("t2_next_arvalid", bus.ifu_arvalid, 1'b1);
        check("t2_next_araddr", bus.ifu_araddr, 32'h8000_0008);

        // Redirect while waiting for a slow response.
        dly_min = 2; dly_max = 2;
        run_until(W_R, 4, "t3_r");
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        expect_dropped("t3", 32'h8000_0100);

        // Redirect while AR is stalled; address must not move.
        dly_min = 0; dly_max = 0;
        ar_pct = 0;
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        check("t4_araddr_hold0", bus.ifu_araddr, 32'h8000_0100);
        repeat (2) begin
            drive();
            tick();
            check("t4_arvalid_hold", bus.ifu_arvalid, 1'b1);
            check("t4_araddr_hold", bus.ifu_araddr, 32'h8000_0100);
        end
        ar_pct = 100;
        drive();
        tick();
        expect_dropped("t4", 32'h8000_0200);

        // Error response, then an OKAY one clears the flag.
        ovr_data = 32'hDEAD_BEEF; ovr_resp = 2'b10;
        run_until(W_VALID, 6, "t5_err");
        check("t5_err", fetch_err, 1'b1);
        check("t5_inst", to_idu_inst, 32'hDEAD_BEEF);
        check("t5_pc", to_idu_pc, 32'h8000_0200);
        drive();
        tick();
        ovr_data = 32'h0000_0013; ovr_resp = 2'b00;
        run_until(W_VALID, 6, "t5_ok");
        check("t5_err_clear", fetch_err, 1'b0);
        check("t5_pc2", to_idu_pc, 32'h8000_0204);

        // Redirect beats allowin in S_OUT; PC wraps past the top of memory.
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        idu_allowin    = 1'b1;
        tick();
        check("t7_cancel_valid", to_idu_valid, 1'b0);
        check("t7_araddr", bus.ifu_araddr, 32'hFFFF_FFFC);
        run_until(W_VALID, 6, "t7_out");
        check("t7_pc", to_idu_pc, 32'hFFFF_FFFC);
        drive();
        tick();
        run_until(W_AR, 3, "t7_wrap");
        check("t7_wrap_araddr", bus.ifu_araddr, 32'h0000_0000);

        // Asynchronous reset in S_R, then redirect+allowin in S_OUT.
        run_until(W_R, 4, "t6_r");
        async_reset("t6_rst");
        run_until(W_AR, 3, "t6_ar");
        check("t6_araddr", bus.ifu_araddr, 32'h8000_0000);
        run_until(W_VALID, 6, "t6_out");
        drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        idu_allowin    = 1'b1;
        tick();
        check("t6_cancel_valid", to_idu_valid, 1'b0);
        run_until(W_AR, 2, "t6_ar2");
        check("t6_redir_araddr", bus.ifu_araddr, 32'h8000_0300);

        // Random traffic: stalls, delays, spurious rvalid, redirects, resets.
        ovr_en = 1'b0; spur_en = 1'b1;
        ar_pct = 70; dly_min = 0; dly_max = 3; redir_pct = 8; allow_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd_rst");
            end else begin
                drive();
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
